// File: rtl/ahb_burst_master.sv
// ahb_burst_master: command-driven AHB-Lite master issuing SINGLE, INCR and fixed INCR/WRAP bursts
module ahb_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [2:0]        cmd_size,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_req,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  input  logic              Hreadyout,
  input  logic [1:0]        Hresp,
  input  logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Htrans,
  output logic [ADDR_W-1:0] Haddr,
  output logic              Hwrite,
  output logic [2:0]        Hburst,
  output logic [2:0]        Hsize,
  output logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyin
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR2} state_t;
  localparam logic [1:0] TR_IDLE = 2'b00, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;
  state_t state, state_n;
  logic [4:0] cnt, total, beats_c, len_c;
  logic [2:0] size_c;
  logic dp, accept, addr_done, data_phase, abort, is_wrap;
  logic [ADDR_W-1:0] inc, mask, next_addr;
  assign cmd_ready  = state == S_IDLE;
  assign accept     = cmd_valid & cmd_ready;
  assign addr_done  = state == S_ADDR & Hreadyout;
  assign data_phase = (state == S_ADDR & dp) | state == S_LAST;
  assign abort      = data_phase & ~Hreadyout & Hresp == 2'b01;
  assign wdata_req  = Hwrite & addr_done;
  assign Hreadyin   = Hreadyout;
  assign size_c     = cmd_size > 3'd2 ? 3'd2 : cmd_size;
  assign len_c      = cmd_len == 5'd0 ? 5'd1 : cmd_len > 5'd16 ? 5'd16 : cmd_len;
  assign beats_c    = cmd_burst == 3'd0 ? 5'd1 : cmd_burst == 3'd1 ? len_c : 5'd4 << (cmd_burst[2:1] - 2'd1);
  assign is_wrap    = Hburst != 3'd0 & ~Hburst[0];
  assign inc        = ADDR_W'(1) << Hsize;
  // wrap window is beats*inc bytes, aligned to its own size
  assign mask       = (ADDR_W'(total) << Hsize) - ADDR_W'(1);
  assign next_addr  = is_wrap ? (Haddr & ~mask) | ((Haddr + inc) & mask) : Haddr + inc;
  // State register
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) state <= S_IDLE;
    else state <= state_n;
  // Next state: accept, last address beat, error abort, final data phase / error second cycle
  always_comb begin
    state_n = accept ? S_ADDR :
              addr_done & cnt == 5'd1 ? S_LAST :
              abort ? S_ERR2 :
              (state == S_LAST | state == S_ERR2) & Hreadyout ? S_IDLE : state;
  end
  // Bus outputs, beat counting, data capture and completion pulses
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) begin
      Htrans      <= TR_IDLE;
      Haddr       <= '0;
      Hwrite      <= 1'b0;
      Hburst      <= 3'd0;
      Hsize       <= 3'd0;
      Hwdata      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cnt         <= 5'd0;
      total       <= 5'd0;
      dp          <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      if (accept) begin
        Htrans <= TR_NONSEQ;
        Haddr  <= cmd_addr;
        Hwrite <= cmd_write;
        Hburst <= cmd_burst;
        Hsize  <= size_c;
        cnt    <= beats_c;
        total  <= beats_c;
        dp     <= 1'b0;
      end else if (abort) begin
        Htrans <= TR_IDLE;
      end else if (Hreadyout) begin
        if (data_phase & ~Hwrite & Hresp == 2'b00) begin
          rdata       <= Hrdata;
          rdata_valid <= 1'b1;
        end
        if (state == S_ADDR) begin
          cnt    <= cnt - 5'd1;
          dp     <= 1'b1;
          Haddr  <= cnt == 5'd1 ? Haddr : next_addr;
          Htrans <= cnt == 5'd1 ? TR_IDLE : ~is_wrap & next_addr[9:0] == 10'd0 ? TR_NONSEQ : TR_SEQ;
          if (Hwrite) Hwdata <= wdata;
        end
        if (state == S_LAST | state == S_ERR2) begin
          done <= 1'b1;
          err  <= state == S_ERR2;
          dp   <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed and random bursts checked against a burst-level reference model
module tb_ahb_burst_master;
  logic        Hclk = 1'b0, Hresetn = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_burst = '0, cmd_size = '0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] wdata = '0, rdata, Hrdata = '0, Haddr, Hwdata;
  logic        wdata_req, rdata_valid, done, err, Hwrite, Hreadyin;
  logic        Hreadyout = 1'b1;
  logic [1:0]  Hresp = 2'b00, Htrans;
  logic [2:0]  Hburst, Hsize;
  logic        wfix_en = 1'b0;
  logic [31:0] wfix = '0;
  int vectors = 0, miscompares = 0;

  ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
    .cmd_len(cmd_len), .wdata(wdata), .wdata_req(wdata_req), .rdata(rdata),
    .rdata_valid(rdata_valid), .done(done), .err(err), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Hrdata(Hrdata), .Htrans(Htrans), .Haddr(Haddr), .Hwrite(Hwrite), .Hburst(Hburst),
    .Hsize(Hsize), .Hwdata(Hwdata), .Hreadyin(Hreadyin)
  );

  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_check();
    check("rst_htrans", 32'(Htrans), 0);
    check("rst_haddr", Haddr, 0);
    check("rst_hwrite", 32'(Hwrite), 0);
    check("rst_hburst", 32'(Hburst), 0);
    check("rst_hsize", 32'(Hsize), 0);
    check("rst_hwdata", Hwdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_valid", 32'(rdata_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
  endtask

  function automatic int beats_of(input logic [2:0] bu, input logic [4:0] ln);
    if (bu == 3'd0) return 1;
    if (bu == 3'd1) return ln == 5'd0 ? 1 : (ln > 5'd16 ? 16 : int'(ln));
    return 4 << ((int'(bu) - 2) / 2);
  endfunction

  // One command end to end; the bench plays the slave. wbeat/wcyc: wait states on that beat's
  // address phase; ebeat: two-cycle ERROR on that beat's data phase; rbeat: reset during that beat.
  task automatic run(input logic wr, input logic [31:0] a, input logic [2:0] bu, input logic [2:0] sz,
                     input logic [4:0] ln, input int wbeat, input int wcyc, input int ebeat, input int rbeat);
    int n, inc, bsz, beat, dpb, waited, ephase, c, lim;
    logic [2:0] szc;
    logic wrap, hr, act, exp_rv, exp_dn, exp_er;
    logic [1:0] resp;
    logic [31:0] base, exp_rd;
    logic [31:0] ea[16];
    logic [1:0] et[16];
    logic [31:0] wq[16];
    szc = sz > 3'd2 ? 3'd2 : sz;
    inc = 1 << szc;
    n = beats_of(bu, ln);
    wrap = bu != 3'd0 && bu[0] == 1'b0;
    bsz = n * inc;
    base = a - (a % 32'(bsz));
    for (int i = 0; i < n; i++) begin
      ea[i] = wrap ? base + (a - base + 32'(i * inc)) % 32'(bsz) : a + 32'(i * inc);
      et[i] = (i == 0 || (!wrap && ea[i][9:0] == 10'd0)) ? 2'b10 : 2'b11;
    end
    Hreadyout = 1'b1;
    Hresp = 2'b00;
    cmd_write = wr; cmd_addr = a; cmd_burst = bu; cmd_size = sz; cmd_len = ln; cmd_valid = 1'b1;
    c = 0;
    while (cmd_ready !== 1'b1 && c < 20) begin
      @(posedge Hclk); #1;
      c++;
    end
    check("cmd_ready", 32'(cmd_ready), 1);
    @(posedge Hclk); #1;
    cmd_valid = 1'b0;
    beat = 0; dpb = -1; waited = 0; ephase = 0;
    exp_rv = 1'b0; exp_dn = 1'b0; exp_er = 1'b0; exp_rd = '0;
    lim = n + wcyc + 6;
    for (c = 0; c <= lim; c++) begin
      if (beat == rbeat) begin
        Hresetn = 1'b0;
        #1;
        reset_check();
        @(posedge Hclk); #1;
        check("no_done_in_reset", 32'(done), 0);
        Hresetn = 1'b1;
        return;
      end
      check("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
      if (exp_rv) check("rdata", rdata, exp_rd);
      check("done", 32'(done), 32'(exp_dn));
      if (exp_dn) begin
        check("err", 32'(err), 32'(exp_er));
        if (!exp_er) check("done_latency", c, n + 1 + wcyc);
        return;
      end
      if (ephase == 1) check("htrans_after_error", 32'(Htrans), 0);
      act = Htrans != 2'b00;
      hr = 1'b1;
      resp = 2'b00;
      if (act && beat == wbeat && waited < wcyc) begin
        hr = 1'b0;
        waited++;
      end
      if (ephase == 1) begin
        resp = 2'b01;
        ephase = 2;
      end else if (dpb >= 0 && dpb == ebeat) begin
        resp = 2'b01;
        hr = 1'b0;
        ephase = 1;
      end
      Hreadyout = hr;
      Hresp = resp;
      Hrdata = $urandom;
      wdata = (wfix_en && beat == 0) ? wfix : $urandom;
      #1;
      check("wdata_req", 32'(wdata_req), 32'(wr & act & hr));
      check("hreadyin", 32'(Hreadyin), 32'(hr));
      if (act) begin
        if (beat < n) begin
          check("haddr", Haddr, ea[beat]);
          check("htrans", 32'(Htrans), 32'(et[beat]));
        end else check("extra_beat", beat, n - 1);
        check("hwrite", 32'(Hwrite), 32'(wr));
        check("hburst", 32'(Hburst), 32'(bu));
        check("hsize", 32'(Hsize), 32'(szc));
        if (hr && beat < 16) wq[beat] = wdata;
      end
      if (dpb >= 0 && wr) check("hwdata", Hwdata, wq[dpb]);
      exp_rv = 1'b0;
      if (hr && resp == 2'b01) begin
        exp_dn = 1'b1;
        exp_er = 1'b1;
        dpb = -1;
      end else if (hr) begin
        if (dpb >= 0 && !wr) begin
          exp_rv = 1'b1;
          exp_rd = Hrdata;
        end
        exp_dn = dpb == n - 1;
        dpb = act ? beat : -1;
        if (act) beat++;
      end
      @(posedge Hclk); #1;
    end
    vectors++;
    miscompares++;
    $error("FAIL timeout: burst not finished within %0d cycles", lim);
  endtask

  initial begin
    #2 Hresetn = 1'b0;
    #1 reset_check();
    repeat (2) @(posedge Hclk);
    #1 Hresetn = 1'b1;
    wfix_en = 1'b1;
    wfix = 32'hA5A5_0001;
    run(1'b1, 32'h8000_0000, 3'd0, 3'd2, 5'd0, -1, 0, -1, -1);
    wfix_en = 1'b0;
    run(1'b1, 32'h8000_0004, 3'd3, 3'd1, 5'd0, -1, 0, -1, -1);
    run(1'b0, 32'h8000_0038, 3'd2, 3'd2, 5'd0, -1, 0, -1, -1);
    run(1'b0, 32'h8000_0100, 3'd5, 3'd1, 5'd0, 2, 2, -1, -1);
    run(1'b1, 32'h8000_0200, 3'd3, 3'd2, 5'd0, -1, 0, 1, -1);
    run(1'b0, 32'h8000_0240, 3'd3, 3'd2, 5'd0, -1, 0, 2, -1);
    run(1'b1, 32'h8000_0300, 3'd7, 3'd2, 5'd0, -1, 0, -1, 2);
    run(1'b1, 32'h8000_0010, 3'd0, 3'd2, 5'd0, -1, 0, -1, -1);
    run(1'b0, 32'h8000_0014, 3'd0, 3'd2, 5'd0, -1, 0, -1, -1);
    run(1'b0, 32'h0000_03F8, 3'd1, 3'd2, 5'd4, -1, 0, -1, -1);
    run(1'b1, 32'h0000_0100, 3'd1, 3'd5, 5'd0, -1, 0, -1, -1);
    run(1'b0, 32'h0000_0000, 3'd1, 3'd0, 5'd20, -1, 0, -1, -1);
    run(1'b0, 32'h8000_0006, 3'd6, 3'd1, 5'd0, 1, 1, -1, -1);
    run(1'b1, 32'h8000_0075, 3'd4, 3'd0, 5'd0, -1, 0, -1, -1);
    for (int k = 0; k < 30; k++) begin
      logic [2:0] bu, sz;
      logic [4:0] ln;
      logic [31:0] a;
      int n, inc;
      bu = 3'($urandom_range(0, 7));
      sz = 3'($urandom_range(0, 3));
      ln = 5'($urandom_range(0, 20));
      n = beats_of(bu, ln);
      inc = 1 << (sz > 3'd2 ? 2 : int'(sz));
      a = 32'h8000_0000 | 32'($urandom_range(0, 1024 / inc - n) * inc);
      run(1'($urandom_range(0, 1)), a, bu, sz, ln, int'($urandom_range(0, n - 1)),
          int'($urandom_range(0, 2)), -1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ahb_burst_master.md
# ahb_burst_master

Synthesizable AHB-Lite master that drives the AHB side of the AHB-to-APB bridge (`bridge_top`). It replaces task-driven stimulus with a command-driven engine. It accepts one transfer command at a time and issues the full burst: SINGLE, INCR, and the fixed INCR/WRAP types. It generates NONSEQ/SEQ `Htrans` and incrementing or wrapping `Haddr`, pipelines `Hwdata` one phase behind the address, and returns read data and completion or error status to the command source.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `Hclk`  in  1  system clock; all logic on its rising edge
- `Hresetn`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  high only in IDLE; command accepted when `cmd_valid & cmd_ready`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  start address; caller aligns it to the size
- `cmd_burst`  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7
- `cmd_size`  in  3  0 = byte, 1 = half, 2 = word; values above 2 are clamped to 2
- `cmd_len`  in  5  beat count, used for INCR only; 0 is treated as 1, values above 16 as 16
- `wdata`  in  DATA_W  write data for the current beat
- `wdata_req`  out  1  pop strobe: `wdata` is sampled on the edge where this is high
- `rdata`  out  DATA_W  captured read data
- `rdata_valid`  out  1  one-cycle pulse per read beat
- `done`  out  1  one-cycle pulse at the end of a burst
- `err`  out  1  valid together with `done`; 1 = burst aborted by ERROR response
- `Hreadyout`  in  1  slave ready, from the bridge
- `Hresp`  in  2  00 = OKAY, 01 = ERROR
- `Hrdata`  in  DATA_W  read data
- `Htrans`  out  2  00 = IDLE, 10 = NONSEQ, 11 = SEQ; BUSY is never driven
- `Haddr`  out  ADDR_W  address
- `Hwrite`  out  1  direction
- `Hburst`  out  3  copy of the latched burst type
- `Hsize`  out  3  latched, clamped size
- `Hwdata`  out  DATA_W  write data
- `Hreadyin`  out  1  combinational copy of `Hreadyout`

## Operation
- States:
  - IDLE: `Htrans`=IDLE, `cmd_ready`=1.
  - ADDR: beats are being issued.
  - LAST: data phase of the final beat.
  - ERR2: second cycle of an ERROR response.
- IDLE→ADDR on command accept.
  - Latches write, burst, size and beat count: 1, len, 4, 8 or 16.
  - Drives `Haddr`=`cmd_addr` and `Htrans`=NONSEQ on the next cycle.
- Address phase completes on an edge with `Hreadyout`=1.
  - Beat counter decrements.
  - Next `Haddr` is computed and `Htrans` becomes SEQ.
  - When the completed beat was the last, the state moves to LAST and `Htrans` becomes IDLE.
- While `Hreadyout`=0, `Haddr`, `Htrans`, `Hwrite`, `Hburst`, `Hsize` and `Hwdata` hold their values.
- Increment is `inc = 1 << size`.
  - INCR*: `next = addr + inc`.
  - WRAP*: with `B = beats*inc`, `next = (addr & ~(B-1)) | ((addr+inc) & (B-1))`.
- INCR crossing a 1 KB boundary (`next[9:0]`==0): the next beat is issued as NONSEQ, not SEQ.
- Write:
  - `wdata_req = Hwrite & Hreadyout` during an address-phase beat.
  - `Hwdata <= wdata` on that edge, so the data phase carries it.
- Read:
  - Data phase completes on `Hreadyout`=1 with `Hresp`=OKAY.
  - On that edge, `rdata <= Hrdata` and `rdata_valid <= 1`.
- LAST→IDLE when the final data phase completes; `done` pulses with `err`=0.
- ERROR handling:
  - `Hresp`=01 with `Hreadyout`=0 in any data phase triggers abort: `Htrans` becomes IDLE on the next edge and the state moves to ERR2.
  - ERR2→IDLE on `Hreadyout`=1; `done`=1 with `err`=1.
  - Remaining beats are dropped; no `rdata_valid` pulse for the errored beat.
- A new command is accepted only in IDLE. No overlap between bursts.

## Timing
- Reset values (async): `Htrans` 00, `Haddr` 0, `Hwrite` 0, `Hburst` 0, `Hsize` 0, `Hwdata` 0, `rdata` 0, `rdata_valid` 0, `done` 0, `err` 0, `cmd_ready` 1, state IDLE.
- Reset mid-burst: everything returns to the reset values immediately. No `done` is issued.
- Latency with zero wait states:
  - Accept edge to first NONSEQ: 1 cycle.
  - N beats occupy N address cycles plus 1 trailing data cycle.
  - `done` arrives N+2 cycles after accept.
- `rdata_valid` follows the completing data-phase edge by 0 cycles: it is registered there and visible in the next cycle.
- `Hreadyin` has no register.

## Test plan
- SINGLE write, `cmd_addr`=0x8000_0000, size 2, `wdata`=0xA5A5_0001, no waits:
  - One NONSEQ at 0x8000_0000.
  - `Hwdata`=0xA5A5_0001 in the following cycle.
  - `done` with `err`=0 at accept+3.
- INCR4 write, half-word, start 0x8000_0004:
  - `Haddr` 04, 06, 08, 0A.
  - `Htrans` NONSEQ, SEQ, SEQ, SEQ.
  - Four `wdata_req` pulses.
- WRAP4 read, word, start 0x8000_0038:
  - `Haddr` 38, 3C, 30, 34.
  - Four `rdata_valid` pulses carrying the `Hrdata` values in order.
- INCR8 read, half-word, `Hreadyout` held low 2 cycles on beat 3:
  - `Haddr` and `Htrans` stable during the wait.
  - Eight reads total; `done` delayed by 2 cycles.
- INCR4 write where beat 2 gets `Hresp`=01 for two cycles (`Hreadyout` 0 then 1):
  - `Htrans`=IDLE the cycle after the first ERROR cycle.
  - `done` with `err`=1; no further beats issued.
- Reset asserted during beat 3 of INCR16, then two back-to-back SINGLE commands after release:
  - Outputs return to reset values immediately.
  - Each command is accepted only when `cmd_ready`=1.
  - Each command completes independently with `err`=0.
